// File: rtl/vsfx_writeback.sv
// vsfx_writeback: in-order result FIFO draining to the VR file, committing VSCR[SAT] and CR6 at retirement
module vsfx_writeback #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_en,
  input  logic [127:0]     res_vrt,
  input  logic             res_sat,
  input  logic [3:0]       res_cr6,
  input  logic             res_rc,
  input  logic [IDX_W-1:0] res_idx,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [IDX_W-1:0] wb_idx,
  output logic [127:0]     wb_data,
  input  logic             vscr_we,
  input  logic             vscr_wdata,
  output logic             vscr_sat,
  output logic [3:0]       cr6,
  output logic             stall,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [127:0]     mem_vrt [DEPTH];
  logic [IDX_W-1:0] mem_idx [DEPTH];
  logic [3:0]       mem_cr6 [DEPTH];
  logic             mem_sat [DEPTH];
  logic             mem_rc  [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt, cnt_nxt;
  logic             full, pop, push, head_sat;
  assign full     = cnt == FULL;
  assign wb_valid = cnt != '0;
  assign pop      = wb_valid & wb_ready;
  assign push     = res_en & (~full | pop);
  assign cnt_nxt  = cnt + (AW+1)'(push) - (AW+1)'(pop);
  assign wb_idx   = wb_valid ? mem_idx[rptr] : '0;
  assign wb_data  = wb_valid ? mem_vrt[rptr] : '0;
  assign head_sat = pop & mem_sat[rptr];
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_vrt[wptr] <= res_vrt;
      mem_idx[wptr] <= res_idx;
      mem_cr6[wptr] <= res_cr6;
      mem_sat[wptr] <= res_sat;
      mem_rc[wptr]  <= res_rc;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      stall    <= 1'b0;
      overflow <= 1'b0;
      vscr_sat <= 1'b0;
      cr6      <= 4'b0000;
    end else begin
      wptr     <= push ? wptr + AW'(1) : wptr;
      rptr     <= pop ? rptr + AW'(1) : rptr;
      cnt      <= cnt_nxt;
      stall    <= cnt_nxt == FULL;
      overflow <= overflow | (res_en & full & ~pop);
      vscr_sat <= (vscr_we ? vscr_wdata : vscr_sat) | head_sat;
      cr6      <= (pop && mem_rc[rptr]) ? mem_cr6[rptr] : cr6;
    end
  end
endmodule

// File: tb/tb_vsfx_writeback.sv
// tb_vsfx_writeback: directed scenarios plus random traffic checked against a queue-based reference model
module tb_vsfx_writeback;
  localparam int DEPTH = 4;
  logic         clk = 0, rst = 0, res_en = 0, res_sat = 0, res_rc = 0, wb_ready = 0;
  logic         vscr_we = 0, vscr_wdata = 0;
  logic [127:0] res_vrt = '0;
  logic [3:0]   res_cr6 = '0;
  logic [4:0]   res_idx = '0;
  logic         wb_valid, vscr_sat, stall, overflow;
  logic [4:0]   wb_idx;
  logic [127:0] wb_data;
  logic [3:0]   cr6;
  int checks = 0, errors = 0;
  typedef struct {logic [4:0] idx; logic [127:0] vrt; logic sat; logic [3:0] cr6; logic rc;} ent_t;
  ent_t q[$];
  logic m_sat = 0, m_ovf = 0;
  logic [3:0] m_cr6 = '0;

  vsfx_writeback #(.DEPTH(DEPTH), .IDX_W(5)) dut (
    .clk(clk), .rst(rst), .res_en(res_en), .res_vrt(res_vrt), .res_sat(res_sat),
    .res_cr6(res_cr6), .res_rc(res_rc), .res_idx(res_idx), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_idx(wb_idx), .wb_data(wb_data), .vscr_we(vscr_we),
    .vscr_wdata(vscr_wdata), .vscr_sat(vscr_sat), .cr6(cr6), .stall(stall), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Advance the reference model by the architectural rules, then one clock edge.
  task automatic cyc();
    ent_t e;
    bit pop;
    pop = q.size() != 0 && wb_ready;
    if (rst) begin
      q.delete(); m_sat = 0; m_cr6 = 0; m_ovf = 0;
    end else begin
      if (pop) begin
        e = q.pop_front();
        if (e.rc) m_cr6 = e.cr6;
      end
      m_sat = (vscr_we ? vscr_wdata : m_sat) | (pop && e.sat);
      if (res_en) begin
        if (q.size() < DEPTH) q.push_back('{res_idx, res_vrt, res_sat, res_cr6, res_rc});
        else m_ovf = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rst = 0; res_en = 0; wb_ready = 0; vscr_we = 0; vscr_wdata = 0;
    res_sat = 0; res_rc = 0; res_cr6 = 0; res_vrt = '0; res_idx = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cyc(); rst = 0;
  endtask

  task automatic push(input logic [4:0] idx, input logic [127:0] vrt, input logic sat,
                      input logic rc, input logic [3:0] c);
    res_en = 1; res_idx = idx; res_vrt = vrt; res_sat = sat; res_rc = rc; res_cr6 = c;
    cyc(); res_en = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({wb_valid, wb_idx, wb_data, vscr_sat, cr6, stall, overflow} !== '0) begin
      errors++; $display("FAIL reset_state: got v=%b idx=%0d data=%h sat=%b cr6=%b stall=%b ovf=%b, want all 0",
                         wb_valid, wb_idx, wb_data, vscr_sat, cr6, stall, overflow);
    end
  endtask

  task automatic test_single();
    wb_ready = 1;
    push(5'd3, 128'h1, 0, 0, 4'h0);
    checks++;
    if (wb_valid !== 1 || wb_idx !== 3 || wb_data !== 128'h1) begin
      errors++; $display("FAIL single_head: got v=%b idx=%0d data=%h, want 1/3/1", wb_valid, wb_idx, wb_data);
    end
    cyc();
    checks++;
    if (wb_valid !== 0 || cr6 !== 0 || vscr_sat !== 0) begin
      errors++; $display("FAIL single_pop: got v=%b cr6=%b sat=%b, want 0/0/0", wb_valid, cr6, vscr_sat);
    end
  endtask

  task automatic test_full_overflow();
    wb_ready = 0;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (stall !== 0) begin errors++; $display("FAIL early_stall: got %b before push %0d, want 0", stall, k); end
      push(5'(k), 128'(k * 17), 0, 0, 4'h0);
    end
    checks++;
    if (stall !== 1 || overflow !== 0) begin
      errors++; $display("FAIL full_stall: got stall=%b ovf=%b, want 1/0", stall, overflow);
    end
    push(5'd5, 128'h55, 0, 0, 4'h0);
    checks++;
    if (overflow !== 1 || stall !== 1 || wb_idx !== 1) begin
      errors++; $display("FAIL overflow: got ovf=%b stall=%b head=%0d, want 1/1/1", overflow, stall, wb_idx);
    end
    wb_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (wb_valid !== 1 || wb_idx !== 5'(k) || wb_data !== 128'(k * 17)) begin
        errors++; $display("FAIL drain_order: got v=%b idx=%0d data=%h, want idx %0d", wb_valid, wb_idx, wb_data, k);
      end
      cyc();
    end
    checks++;
    if (wb_valid !== 0 || stall !== 0 || overflow !== 1) begin
      errors++; $display("FAIL drain_end: got v=%b stall=%b ovf=%b, want 0/0/1", wb_valid, stall, overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp[4] = '{5'd11, 5'd12, 5'd13, 5'd9};
    do_reset();
    for (int k = 10; k <= 13; k++) push(5'(k), 128'(k), 0, 0, 4'h0);
    wb_ready = 1;
    push(5'd9, 128'h9, 0, 0, 4'h0);
    checks++;
    if (stall !== 1 || overflow !== 0 || wb_idx !== 11) begin
      errors++; $display("FAIL push_pop_full: got stall=%b ovf=%b head=%0d, want 1/0/11", stall, overflow, wb_idx);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wb_valid !== 1 || wb_idx !== exp[k]) begin
        errors++; $display("FAIL b2b_order: got v=%b idx=%0d, want %0d", wb_valid, wb_idx, exp[k]);
      end
      cyc();
    end
  endtask

  task automatic test_commit();
    do_reset();
    wb_ready = 1;
    push(5'd1, 128'h0, 1, 1, 4'b1000);
    push(5'd2, 128'h0, 0, 0, 4'b0010);
    cyc();
    checks++;
    if (vscr_sat !== 1 || cr6 !== 4'b1000) begin
      errors++; $display("FAIL commit: got sat=%b cr6=%b, want 1/1000", vscr_sat, cr6);
    end
  endtask

  task automatic test_vscr_write();
    do_reset();
    push(5'd7, 128'h7, 1, 0, 4'h0);
    wb_ready = 1; vscr_we = 1; vscr_wdata = 0;
    cyc();
    checks++;
    if (vscr_sat !== 1) begin errors++; $display("FAIL sat_beats_clear: got %b, want 1", vscr_sat); end
    cyc();
    checks++;
    if (vscr_sat !== 0) begin errors++; $display("FAIL sw_clear: got %b, want 0", vscr_sat); end
    vscr_wdata = 1; cyc();
    checks++;
    if (vscr_sat !== 1) begin errors++; $display("FAIL sw_set: got %b, want 1", vscr_sat); end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 5; k++) push(5'(20 + k), 128'(k), 1, 1, 4'hf);
    wb_ready = 1; cyc(); wb_ready = 0;
    checks++;
    if (cr6 !== 4'hf || overflow !== 1 || wb_valid !== 1) begin
      errors++; $display("FAIL pre_reset: got cr6=%b ovf=%b v=%b, want 1111/1/1", cr6, overflow, wb_valid);
    end
    wb_ready = 1; res_en = 1; rst = 1; cyc(); idle();
    checks++;
    if (wb_valid !== 0 || stall !== 0 || overflow !== 0 || cr6 !== 0 || vscr_sat !== 0) begin
      errors++; $display("FAIL reset_mid: got v=%b stall=%b ovf=%b cr6=%b sat=%b, want 0", wb_valid, stall, overflow, cr6, vscr_sat);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      res_en = $urandom_range(0, 99) < 60; wb_ready = $urandom_range(0, 99) < 45;
      vscr_we = $urandom_range(0, 99) < 8; vscr_wdata = 1'($urandom);
      res_idx = 5'($urandom); res_vrt = {$urandom, $urandom, $urandom, $urandom};
      res_sat = $urandom_range(0, 99) < 20; res_rc = 1'($urandom); res_cr6 = 4'($urandom);
      rst = $urandom_range(0, 199) == 0;
      cyc();
      checks++;
      if (wb_valid !== (q.size() != 0) || stall !== (q.size() == DEPTH) || overflow !== m_ovf ||
          vscr_sat !== m_sat || cr6 !== m_cr6 ||
          (q.size() != 0 && (wb_idx !== q[0].idx || wb_data !== q[0].vrt))) begin
        errors++;
        $display("FAIL random[%0d]: got v=%b stall=%b ovf=%b sat=%b cr6=%b idx=%0d, want v=%b stall=%b ovf=%b sat=%b cr6=%b idx=%0d",
                 n, wb_valid, stall, overflow, vscr_sat, cr6, wb_idx, q.size() != 0, q.size() == DEPTH,
                 m_ovf, m_sat, m_cr6, q.size() != 0 ? q[0].idx : 5'd0);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_overflow();
    test_back_to_back();
    test_commit();
    test_vscr_write();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
